// File: rtl/sha2_msg_scheduler.sv
// sha2_msg_scheduler
//   SHA-2 message-schedule generator. A 16-word padded chunk is loaded into a
//   sliding window and W_0..W_{ROUNDS-1} are streamed one word per cycle to the
//   round engine over a valid/ready link. WORD_W=32 selects the SHA-224/256
//   sigma functions and WORD_W=64 selects the SHA-384/512 ones. A one-chunk
//   pending buffer lets the next chunk start the cycle after the last word
//   of the current chunk is taken, so back-to-back chunks have no bubbles.
//
//   Optional feature macro: SHA2_MSG_ABORT_EN adds the abort input, which
//   discards the window and the pending chunk.
//
// Ports
//   clk         clock
//   rst         synchronous, active-high reset
//   chunk_vld   chunk offered
//   chunk_rdy   chunk accepted when chunk_vld & chunk_rdy (= ~pend_vld)
//   chunk_data  16 words, chunk_data[0] = W_0
//   w_vld       w_data valid
//   w_rdy       round engine takes the word when w_vld & w_rdy
//   w_data      W_t
//   w_idx       t
//   w_last      t == ROUNDS-1 (qualified by w_vld)
//   abort       only with SHA2_MSG_ABORT_EN
//   busy        window or pending buffer occupied
module sha2_msg_scheduler #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64,
  localparam int unsigned IDX_W = $clog2(ROUNDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   chunk_vld,
  output logic                   chunk_rdy,
  input  logic [15:0][WORD_W-1:0] chunk_data,
  output logic                   w_vld,
  input  logic                   w_rdy,
  output logic [WORD_W-1:0]      w_data,
  output logic [IDX_W-1:0]       w_idx,
  output logic                   w_last,
`ifdef SHA2_MSG_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   busy
);

  // Elaboration-time parameter checks.
  if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
    $error("sha2_msg_scheduler: WORD_W must be 32 or 64");
  end
  if (ROUNDS < 16 || ROUNDS > 127) begin : g_bad_rounds
    $error("sha2_msg_scheduler: ROUNDS must be in 16..127");
  end

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else              return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else              return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Window: win_q[0] is W_t, win_q[15] is W_{t+15}.
  logic [15:0][WORD_W-1:0] win_q, win_d;
  logic [15:0][WORD_W-1:0] pend_q, pend_d;
  logic                    win_vld_q, win_vld_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [IDX_W-1:0]        t_q, t_d;

  logic              abort_req;
  logic              accept;
  logic              emit;
  logic              at_last;
  logic              win_free;
  logic [WORD_W-1:0] nw;

`ifdef SHA2_MSG_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // W_{t+16} from the current window.
  assign nw = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  // chunk_rdy comes straight from the pend_vld flop; abort only masks it.
  assign chunk_rdy = ~pend_vld_q & ~abort_req;
  assign accept    = chunk_vld & chunk_rdy;
  assign at_last   = (t_q == IDX_W'(ROUNDS - 1));
  assign emit      = win_vld_q & w_rdy;
  assign win_free  = ~win_vld_q | (emit & at_last);

  assign w_vld  = win_vld_q;
  assign w_data = win_q[0];
  assign w_idx  = t_q;
  assign w_last = win_vld_q & at_last;
  assign busy   = win_vld_q | pend_vld_q;

  always_comb begin
    win_d      = win_q;
    pend_d     = pend_q;
    win_vld_d  = win_vld_q;
    pend_vld_d = pend_vld_q;
    t_d        = t_q;

    if (emit) begin
      win_d = {nw, win_q[15:1]};
      if (at_last) begin
        win_vld_d = 1'b0;
        t_d       = '0;
      end else begin
        t_d = t_q + IDX_W'(1);
      end
    end

    // The pending chunk always has priority over a newly offered one; while it
    // is held chunk_rdy is low, so accept cannot coincide with a pend load.
    if (win_free && pend_vld_q) begin
      win_d      = pend_q;
      win_vld_d  = 1'b1;
      t_d        = '0;
      pend_vld_d = 1'b0;
    end else if (win_free && accept) begin
      win_d     = chunk_data;
      win_vld_d = 1'b1;
      t_d       = '0;
    end else if (accept) begin
      pend_d     = chunk_data;
      pend_vld_d = 1'b1;
    end

    if (abort_req) begin
      win_vld_d  = 1'b0;
      pend_vld_d = 1'b0;
      t_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q      <= '0;
      pend_q     <= '0;
      win_vld_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      t_q        <= '0;
    end else begin
      win_q      <= win_d;
      pend_q     <= pend_d;
      win_vld_q  <= win_vld_d;
      pend_vld_q <= pend_vld_d;
      t_q        <= t_d;
    end
  end

endmodule

// File: tb/tb_sha2_msg_scheduler.sv
// Bench for sha2_msg_scheduler: a 32-bit/64-round instance and a 64-bit/80-round
// instance, checked every cycle against an array-based SHA-2 schedule model.
module tb_sha2_msg_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic              cv32, cr32, wv32, wr32, wl32, busy32;
  logic [15:0][31:0] cd32;
  logic [31:0]       wd32;
  logic [5:0]        wi32;
  logic              cv64, cr64, wv64, wr64, wl64, busy64;
  logic [15:0][63:0] cd64;
  logic [63:0]       wd64;
  logic [6:0]        wi64;
`ifdef SHA2_MSG_ABORT_EN
  logic              ab32;
`endif

  sha2_msg_scheduler #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clk(clk), .rst(rst), .chunk_vld(cv32), .chunk_rdy(cr32), .chunk_data(cd32),
    .w_vld(wv32), .w_rdy(wr32), .w_data(wd32), .w_idx(wi32), .w_last(wl32),
`ifdef SHA2_MSG_ABORT_EN
    .abort(ab32),
`endif
    .busy(busy32)
  );

  sha2_msg_scheduler #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk(clk), .rst(rst), .chunk_vld(cv64), .chunk_rdy(cr64), .chunk_data(cd64),
    .w_vld(wv64), .w_rdy(wr64), .w_data(wd64), .w_idx(wi64), .w_last(wl64),
`ifdef SHA2_MSG_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy64)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: plain array recurrence ----------------
  logic [63:0] tmp_w [128];

  function automatic logic [63:0] msk(input logic [63:0] x, input int w);
    return (w == 32) ? (x & 64'hFFFF_FFFF) : x;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [31:0] y;
    y = x[31:0];
    if (w == 32) return {32'h0, (y >> n) | (y << (32 - n))};
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] ms0(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3);
    return rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] ms1(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10);
    return rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
  endfunction

  task automatic sched(input logic [15:0][63:0] blk, input int w, input int r);
    for (int t = 0; t < r; t++) begin
      if (t < 16) tmp_w[t] = msk(blk[t], w);
      else tmp_w[t] = msk(ms1(tmp_w[t-2], w) + tmp_w[t-7] + ms0(tmp_w[t-15], w) + tmp_w[t-16], w);
    end
  endtask

  // ---------------- scoreboard: ring of expected (word, index) ----------------
  logic [63:0] exp_w [2][256];
  int          exp_i [2][256];
  int          head [2] = '{0, 0};
  int          cnt  [2] = '{0, 0};
  int          nch  [2] = '{0, 0};
  logic [63:0] log_w [2][128];
  int          run0 = 0;
  int          maxrun0 = 0;
  logic [15:0][63:0] ext32;

  task automatic sb_step(input int d, input int w, input int r, input logic vld, input logic rdy,
                         input logic [63:0] data, input int idx, input logic last,
                         input logic bsy, input logic crdy, input logic cvld,
                         input logic [15:0][63:0] blk, input logic clr);
    string p;
    int hd;
    int slot;
    p = (d == 0) ? "d32" : "d64";
    if (clr) begin
      cnt[d] = 0; nch[d] = 0; head[d] = 0;
      if (d == 0) run0 = 0;
      return;
    end
    if (d == 0) begin
      run0 = vld ? run0 + 1 : 0;
      if (run0 > maxrun0) maxrun0 = run0;
    end
    check({p, " w_vld"}, {63'h0, vld}, {63'h0, cnt[d] != 0});
    check({p, " busy"}, {63'h0, bsy}, {63'h0, cnt[d] != 0});
    check({p, " chunk_rdy"}, {63'h0, crdy}, {63'h0, nch[d] < 2});
    if (vld && cnt[d] != 0) begin
      hd = head[d];
      check({p, " w_data"}, data, exp_w[d][hd]);
      check({p, " w_idx"}, 64'(idx), 64'(exp_i[d][hd]));
      check({p, " w_last"}, {63'h0, last}, {63'h0, exp_i[d][hd] == r - 1});
      if (rdy) begin
        log_w[d][exp_i[d][hd]] = data;
        if (exp_i[d][hd] == r - 1) nch[d]--;
        head[d] = (hd + 1) % 256;
        cnt[d]--;
      end
    end
    if (cvld && crdy) begin
      sched(blk, w, r);
      for (int t = 0; t < r; t++) begin
        slot = (head[d] + cnt[d]) % 256;
        exp_w[d][slot] = tmp_w[t];
        exp_i[d][slot] = t;
        cnt[d]++;
      end
      nch[d]++;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 16; i++) ext32[i] = {32'h0, cd32[i]};
`ifdef SHA2_MSG_ABORT_EN
    sb_step(0, 32, 64, wv32, wr32, {32'h0, wd32}, int'(wi32), wl32, busy32, cr32, cv32, ext32,
            rst | ab32);
`else
    sb_step(0, 32, 64, wv32, wr32, {32'h0, wd32}, int'(wi32), wl32, busy32, cr32, cv32, ext32,
            rst);
`endif
    sb_step(1, 64, 80, wv64, wr64, wd64, int'(wi64), wl64, busy64, cr64, cv64, cd64, rst);
  end

  // ---------------- stimulus helpers (called at posedge + 1) ----------------
  task automatic offer32(input logic [15:0][31:0] b);
    int n;
    n = 0;
    cd32 = b;
    cv32 = 1'b1;
    forever begin
      @(negedge clk);
      if (cr32) break;
      n++;
      if (n > 500) begin
        n_cmp++; n_err++;
        $display("FAIL offer32 timeout: chunk_rdy stayed %0b want 1", cr32);
        break;
      end
    end
    @(posedge clk); #1;
    cv32 = 1'b0;
  endtask

  task automatic offer64(input logic [15:0][63:0] b);
    int n;
    n = 0;
    cd64 = b;
    cv64 = 1'b1;
    forever begin
      @(negedge clk);
      if (cr64) break;
      n++;
      if (n > 500) begin
        n_cmp++; n_err++;
        $display("FAIL offer64 timeout: chunk_rdy stayed %0b want 1", cr64);
        break;
      end
    end
    @(posedge clk); #1;
    cv64 = 1'b0;
  endtask

  task automatic wait_drain(input bit rnd);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (rnd) wr32 = 1'($urandom_range(0, 1));
      if (cnt[0] == 0 && cnt[1] == 0) break;
    end
    if (n >= 3000) begin
      n_cmp++; n_err++;
      $display("FAIL drain timeout: pending words %0d/%0d want 0", cnt[0], cnt[1]);
    end
    wr32 = 1'b1;
  endtask

  task automatic wait_idx32(input int k);
    int n;
    for (n = 0; n < 500; n++) begin
      @(posedge clk); #1;
      if (wv32 && int'(wi32) == k) break;
    end
    if (n >= 500) begin
      n_cmp++; n_err++;
      $display("FAIL wait idx timeout: w_idx %0d want %0d", wi32, k);
    end
  endtask

  logic [15:0][31:0] abc32, blk_b, blk_c;
  logic [15:0][63:0] abc64, tmp_blk;

  initial begin
    rst = 1'b1; cv32 = 1'b0; cv64 = 1'b0; wr32 = 1'b1; wr64 = 1'b1;
    cd32 = '0; cd64 = '0;
`ifdef SHA2_MSG_ABORT_EN
    ab32 = 1'b0;
`endif
    abc32 = '0; abc32[0] = 32'h6162_6380; abc32[15] = 32'h18;
    abc64 = '0; abc64[0] = 64'h6162_6380_0000_0000; abc64[15] = 64'h18;
    for (int i = 0; i < 16; i++) begin
      blk_b[i] = (32'h0123_4567 * 32'(i + 1)) ^ 32'(i);
      blk_c[i] = $urandom;
    end

    // Pin the model with known SHA-256 / SHA-512 "abc" schedule words.
    for (int i = 0; i < 16; i++) tmp_blk[i] = {32'h0, abc32[i]};
    sched(tmp_blk, 32, 64);
    check("model256 W16", tmp_w[16], 64'h6162_6380);
    check("model256 W17", tmp_w[17], 64'h000F_0000);
    check("model256 W18", tmp_w[18], 64'h7DA8_6405);
    check("model256 W19", tmp_w[19], 64'h6000_03C6);
    sched(abc64, 64, 80);
    check("model512 W16", tmp_w[16], 64'h6162_6380_0000_0000);
    check("model512 W17", tmp_w[17], 64'h0003_0000_0000_00C0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst w_vld", {63'h0, wv32}, 64'h0);
    check("rst chunk_rdy", {63'h0, cr32}, 64'h1);
    check("rst w_data", {32'h0, wd32}, 64'h0);
    check("rst w_idx", {58'h0, wi32}, 64'h0);
    check("rst w_last", {63'h0, wl32}, 64'h0);
    check("rst busy", {63'h0, busy32}, 64'h0);
    check("rst d64 w_data", wd64, 64'h0);
    @(posedge clk); #1;

    // T1: SHA-256 "abc", w_rdy=1; W_0 one cycle after acceptance.
    offer32(abc32);
    check("t1 latency w_vld", {63'h0, wv32}, 64'h1);
    check("t1 first w_idx", {58'h0, wi32}, 64'h0);
    check("t1 first w_data", {32'h0, wd32}, 64'h6162_6380);
    wait_drain(1'b0);
    check("t1 W16", log_w[0][16], 64'h6162_6380);
    check("t1 W17", log_w[0][17], 64'h000F_0000);
    check("t1 W18", log_w[0][18], 64'h7DA8_6405);
    check("t1 W19", log_w[0][19], 64'h6000_03C6);

    // T2: SHA-512 "abc", 80 rounds.
    offer64(abc64);
    check("t2 latency w_vld", {63'h0, wv64}, 64'h1);
    wait_drain(1'b0);
    check("t2 W16", log_w[1][16], 64'h6162_6380_0000_0000);
    check("t2 W17", log_w[1][17], 64'h0003_0000_0000_00C0);

    // T3: three chunks back to back.
    offer32(abc32);
    offer32(blk_b);
    check("t3 chunk_rdy pend full", {63'h0, cr32}, 64'h0);
    offer32(blk_c);
    wait_drain(1'b0);
    check("t3 gapless w_vld run", 64'(maxrun0), 64'd192);

    // T4: random w_rdy stalls.
    offer32(abc32);
    wait_drain(1'b1);
    check("t4 W18", log_w[0][18], 64'h7DA8_6405);
    check("t4 W19", log_w[0][19], 64'h6000_03C6);

    // T5: reset mid-chunk with the pending buffer full.
    offer32(blk_b);
    offer32(blk_c);
    wait_idx32(30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5 w_vld after rst", {63'h0, wv32}, 64'h0);
    check("t5 chunk_rdy after rst", {63'h0, cr32}, 64'h1);
    check("t5 busy after rst", {63'h0, busy32}, 64'h0);
    offer32(abc32);
    check("t5 restart w_idx", {58'h0, wi32}, 64'h0);
    check("t5 restart w_data", {32'h0, wd32}, 64'h6162_6380);
    wait_drain(1'b0);

`ifdef SHA2_MSG_ABORT_EN
    // T6: abort at t=10 while another chunk is offered.
    offer32(blk_b);
    wait_idx32(10);
    ab32 = 1'b1; cd32 = blk_c; cv32 = 1'b1;
    @(negedge clk);
    check("t6 chunk_rdy during abort", {63'h0, cr32}, 64'h0);
    @(posedge clk); #1;
    ab32 = 1'b0; cv32 = 1'b0;
    check("t6 w_vld after abort", {63'h0, wv32}, 64'h0);
    check("t6 chunk_rdy after abort", {63'h0, cr32}, 64'h1);
    check("t6 busy after abort", {63'h0, busy32}, 64'h0);
    offer32(blk_c);
    check("t6 restart w_idx", {58'h0, wi32}, 64'h0);
    check("t6 restart w_data", {32'h0, wd32}, {32'h0, blk_c[0]});
    wait_drain(1'b0);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
